sig_interp_sched: RTL
=====================

# sig_interp_sched

Round-robin scheduler that shares one piecewise-linear sigmoid interpolator and its sample table between several LSTM gate requesters (forget, input, output). Each accepted request carries a signed Q4.4 operand; the block splits it into table index and 4-bit remainder, reads the two bracketing samples, interpolates, and returns a tagged Q0.7 result. It sits between the gate layer datapaths and the shared activation hardware, replacing per-gate sigmoid copies.

## Interface
- NREQ, 3: number of requesters (1..4)
- W, 8: operand/result width
- FRAC, 4: remainder bits (interpolation step = 2^-FRAC)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  request present, bit i = requester i
- req_x  in  NREQ*W  signed Q4.4 operands, requester i at bits [i*W +: W]
- req_ready  out  NREQ  one-hot or zero; request i accepted when req_valid[i] && req_ready[i]
- rsp_valid  out  1  result available
- rsp_id  out  2  requester index of the result
- rsp_y  out  W  signed result, Q0.7 (0..127)
- rsp_ready  in  1  consumer accepts result

## Operation
- Table: 17 entries, T[k] = round(127*sigmoid(k-8)), k=0..16 (T[0]=0, T[8]=64, T[9]=93, T[16]=127).
- Split: idx = x[7:4] + 8 (signed nibble offset, 0..15), rem = x[3:0] unsigned.
- Interpolation: base=T[idx], next=T[idx+1]; diff = next-base as 9-bit signed; prod = diff*rem (13-bit signed); y = base + (prod >>> FRAC), truncated to W bits. No saturation needed (table monotonic, result stays 0..127).
- Arbitration: round-robin pointer ptr (reset 0). Grant = first i with req_valid[i] searching ptr, ptr+1, ... mod NREQ. On acceptance ptr <- granted+1 mod NREQ; otherwise ptr holds.
- Pipeline (3 registered stages, each with valid bit):
  - S1: id, idx, rem captured on acceptance.
  - S2: base, next registered from table (registered table read), id, rem forwarded.
  - S3: y, id registered; drives rsp_*.
- Global stall: adv = !S3.valid || rsp_ready. When adv=0 all stages hold, req_ready = 0.
- req_ready[i] = adv && grant[i]; depends on req_valid (combinational path req_valid -> req_ready permitted); requesters must not make req_valid depend on req_ready.
- Bubbles propagate as invalid stages; no compaction.

## Timing
- Reset: req_ready=0 during rst, rsp_valid=0, rsp_id=0, rsp_y=0, all valid bits 0, ptr=0.
- Latency: request accepted in cycle n -> rsp_valid high in cycle n+3 (no stall).
- Throughput: one request per cycle while rsp_ready held high.
- rsp_valid/rsp_id/rsp_y stable while rsp_valid && !rsp_ready.
- Simultaneous rsp handshake and new acceptance in same cycle: both occur, pipeline advances.
- rst mid-operation: all in-flight results discarded, no rsp_valid in the cycle after reset deasserts.
- x=0x7F (max): idx=15, rem=15 -> uses T[16]; x=0x80 (min): idx=0, rem=0.

## Structure
- Package sig_interp_pkg: W, FRAC, table depth (17), table constant array T, id width, Q-format notes.
- Sub-module sig_interp_core: combinational base/next/rem -> y (the interpolation formula above); scheduler owns arbitration, split, table register and pipeline.
- Table as constant array indexed in S1->S2 transition (infers ROM/LUTs).

## Test plan
- Single request, requester 0, x=0x00, rsp_ready=1 -> 3 cycles later rsp_valid=1, rsp_id=0, rsp_y=64.
- Requester 1, x=0x08 -> rsp_y = 64 + ((29*8)>>>4) = 78, rsp_id=1; x=0x80 -> 0; x=0x7F -> 127 (within 1 LSB of table endpoint).
- All three req_valid held with distinct x for 6 cycles -> grants in order 0,1,2,0,1,2; responses in same order, one per cycle, each y matching golden model.
- rsp_ready low for 4 cycles with pipeline full -> req_ready all 0, rsp_* frozen, no result lost or duplicated after release.
- Assert rst with 3 requests in flight -> after release no spurious rsp_valid, ptr restarts at 0 (requester 0 granted first when all valid).
- Random sweep of all 256 x across random requesters and random rsp_ready -> every result matches reference formula bit-exactly, per-requester order preserved.

Source files
------------

// File: rtl/sig_interp_pkg.sv
// Shared constants, sigmoid sample table and result payload for the sigmoid interpolation scheduler.
// Operands are signed Q4.4, results are Q0.7 carried in W bits (always 0..127).
package sig_interp_pkg;

    localparam int unsigned W         = 8;
    localparam int unsigned FRAC      = 4;
    localparam int unsigned TBL_DEPTH = 17;
    localparam int unsigned IDX_W     = W - FRAC;
    localparam int unsigned TBL_AW    = IDX_W + 1;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned DIFF_W    = W + 1;
    localparam int unsigned PROD_W    = DIFF_W + FRAC;

    // T[k] = round(127 * sigmoid(k - 8)), k = 0..16
    localparam logic [W-1:0] SIG_TBL [TBL_DEPTH] = '{
        8'd0,   8'd0,   8'd0,   8'd1,   8'd2,   8'd6,   8'd15,  8'd34,
        8'd64,  8'd93,  8'd112, 8'd121, 8'd125, 8'd126, 8'd127, 8'd127,
        8'd127
    };

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [W-1:0]    y;
    } rsp_t;

endpackage

// File: rtl/sig_interp_core.sv
// Combinational linear interpolation between two bracketing sigmoid samples.
module sig_interp_core
    import sig_interp_pkg::*;
(
    input  logic [W-1:0]    i_base,
    input  logic [W-1:0]    i_next,
    input  logic [FRAC-1:0] i_rem,
    output logic [W-1:0]    o_y_c
);

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [PROD_W-1:0] w_diff_x;
    logic signed [PROD_W-1:0] w_rem_x;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_step;

    assign w_diff   = $signed({1'b0, i_next}) - $signed({1'b0, i_base});
    assign w_diff_x = {{(PROD_W-DIFF_W){w_diff[DIFF_W-1]}}, w_diff};
    assign w_rem_x  = {{(PROD_W-FRAC){1'b0}}, i_rem};
    assign w_prod   = w_diff_x * w_rem_x;
    assign w_step   = w_prod >>> FRAC;

    // Table is monotonic, so the sum never leaves 0..127 and truncation is exact.
    assign o_y_c = W'(w_step + PROD_W'(i_base));

endmodule

// File: rtl/sig_interp_sched.sv
// Round-robin front end sharing one sigmoid interpolator among NREQ gate requesters,
// with a three-stage (capture / table read / interpolate) pipeline and a global stall.
module sig_interp_sched
    import sig_interp_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_x,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [ID_W-1:0]   rsp_id,
    output logic [W-1:0]      rsp_y,
    input  logic              rsp_ready
);

    logic [ID_W-1:0]  r_ptr;
    logic             r_s1_valid;
    logic [ID_W-1:0]  r_s1_id;
    logic [IDX_W-1:0] r_s1_idx;
    logic [FRAC-1:0]  r_s1_rem;
    logic             r_s2_valid;
    logic [ID_W-1:0]  r_s2_id;
    logic [FRAC-1:0]  r_s2_rem;
    logic [W-1:0]     r_s2_base;
    logic [W-1:0]     r_s2_next;
    logic             r_s3_valid;
    rsp_t             r_s3;

    logic [W-1:0]     w_x [NREQ];
    logic [NREQ-1:0]  w_grant;
    logic [ID_W-1:0]  w_gid;
    logic [ID_W-1:0]  w_j;
    logic [W-1:0]     w_sel_x;
    logic             w_found;
    logic             w_adv;
    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [FRAC-1:0]  w_rem;
    logic [W-1:0]     w_y_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_x
        assign w_x[g] = req_x[g*W +: W];
    end

    // Round-robin search starting at r_ptr.
    always_comb begin
        w_grant = '0;
        w_gid   = '0;
        w_j     = '0;
        w_sel_x = '0;
        w_found = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_j = ID_W'((32'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_j]) begin
                w_found        = 1'b1;
                w_grant[w_j]   = 1'b1;
                w_gid          = w_j;
                w_sel_x        = w_x[w_j];
            end
        end
    end

    assign w_adv     = !r_s3_valid || rsp_ready;
    assign w_accept  = w_adv && !rst && w_found;
    assign req_ready = (w_adv && !rst) ? w_grant : '0;

    // Signed integer nibble -8..7 offset to table index 0..15.
    assign w_idx = w_sel_x[W-1:FRAC] + IDX_W'(TBL_DEPTH / 2);
    assign w_rem = w_sel_x[FRAC-1:0];

    sig_interp_core u_core (
        .i_base (r_s2_base),
        .i_next (r_s2_next),
        .i_rem  (r_s2_rem),
        .o_y_c  (w_y_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_idx   <= '0;
            r_s1_rem   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_rem   <= '0;
            r_s2_base  <= '0;
            r_s2_next  <= '0;
            r_s3_valid <= 1'b0;
            r_s3       <= '0;
        end else if (w_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_id  <= w_gid;
                r_s1_idx <= w_idx;
                r_s1_rem <= w_rem;
                r_ptr    <= ID_W'((32'(w_gid) + 32'd1) % NREQ);
            end
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_rem   <= r_s1_rem;
            r_s2_base  <= SIG_TBL[TBL_AW'(r_s1_idx)];
            r_s2_next  <= SIG_TBL[TBL_AW'(r_s1_idx) + TBL_AW'(1)];
            r_s3_valid <= r_s2_valid;
            r_s3       <= '{id: r_s2_id, y: w_y_c};
        end
    end

    assign rsp_valid = r_s3_valid;
    assign rsp_id    = r_s3.id;
    assign rsp_y     = r_s3.y;

endmodule
